sram_fifo_drain: RTL and testbench
==================================

Name: sram_fifo_drain

Overview:
- Read-side consumer of the SRAM peripheral's 17-bit synchronous FIFO.
- Pops entries, decodes each as {last, data[15:0]} and writes them to an external asynchronous SRAM at sequential addresses, with programmable write wait-states.
- Sits between the pixel write FIFO and the SRAM pins; signals end of frame to the image-processing controller.

Parameters:
- DATA_W, 16, SRAM data width; FIFO entry is DATA_W+1 bits.
- ADDR_W, 18, SRAM word-address width.
- WAIT_STATES, 2, extra cycles we_n is held low (0..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  permit new pops; sampled only in IDLE/HOLD.
- base_addr  in  ADDR_W  frame start address; captured at first pop of a frame.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W+1  FIFO dataOut, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  one-cycle pop request.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_o  out  DATA_W  write data.
- sram_dq_oe  out  1  data bus drive enable.
- sram_ce_n, sram_we_n, sram_oe_n  out  1 each  SRAM strobes, active-low.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the word whose last bit is 1 completes.

Behaviour:
- Reset (async, immediate): state IDLE; fifo_rd_en=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, busy=0, frame_done=0; frame_active=0. Reset mid-write forces strobes inactive in the same instant; the partial word is lost.
- FSM: IDLE -> POP -> LATCH -> SETUP -> WRITE -> HOLD.
- IDLE: if enable && !fifo_empty, go to POP. If !frame_active, load addr_reg <= base_addr and set frame_active.
- POP: fifo_rd_en=1 for exactly this cycle. fifo_rd_en is never asserted while fifo_empty=1.
- LATCH: capture fifo_data into word_reg (FIFO has 1-cycle registered read latency).
- SETUP (1 cycle): drive sram_addr=addr_reg and sram_dq_o=word_reg.data; sram_ce_n=0, sram_dq_oe=1, sram_we_n=1.
- WRITE (WAIT_STATES+1 cycles, counted by the wait timer): sram_we_n=0; address and data stable.
- HOLD (1 cycle): sram_we_n=1; ce_n, dq and addr still held (data hold time).
  - Then addr_reg <= addr_reg+1, wrapping modulo 2^ADDR_W with no error.
  - If word_reg.last: frame_done=1 this cycle, frame_active=0.
  - Next state: POP if enable && !fifo_empty, else IDLE. IDLE deasserts ce_n and dq_oe.
- Per-word latency: POP to HOLD = 4+WAIT_STATES cycles; back-to-back words need 5+WAIT_STATES cycles (7 at default).
- enable dropped mid-word: current word completes; no further pop.
- sram_oe_n stays 1 at all times in the base configuration.
- base_addr changes while frame_active have no effect until after the next frame_done.

Optional Feature:
- Macro: SRAM_FIFO_DRAIN_VERIFY_EN.
- With the macro defined:
  - Adds port sram_dq_i (in, DATA_W) and verify_err (out, 1, sticky; cleared only by reset).
  - After HOLD, adds state VERIFY: dq_oe=0, oe_n=0, ce_n=0 for WAIT_STATES+1 cycles. sram_dq_i is sampled on the last cycle and compared to word_reg.data; a mismatch sets verify_err.
  - Address increment, frame_done and the next-state decision move from HOLD to the end of VERIFY.
- Without the macro: neither port exists, there is no VERIFY state, and oe_n is constant 1.

Decomposition:
- Package sram_pkg:
  - drain_state_t enum.
  - fifo_entry_t packed struct {logic last; logic [DATA_W-1:0] data}.
  - Default DATA_W/ADDR_W constants.
  - Strobe inactive-level constants.
- One sub-module, sram_wait_timer: loadable down-counter (load WAIT_STATES, done when 0), reused for WRITE and VERIFY.

Test Plan:
- FIFO holds 0x0ABCD (last=0), base_addr=0x00100, enable=1 -> single fifo_rd_en pulse; we_n low for exactly 3 cycles with addr=0x00100, dq=0xABCD; next address 0x00101.
- Stream of 4 words, last set on 4th, base_addr=0x3FFFE -> writes land at 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; one frame_done pulse in the 4th HOLD cycle; 7-cycle spacing between fifo_rd_en pulses.
- fifo_empty toggles high between words -> no fifo_rd_en while empty; returns to IDLE with ce_n=1, busy=0.
- Drop enable during WRITE of word 2 of 3 -> word 2 completes, word 3 is not popped, FSM goes to IDLE.
- Assert rst_n=0 mid-WRITE -> we_n=1, ce_n=1, dq_oe=0 before the next clk edge; after release, the new frame restarts at the current base_addr.
- VERIFY_EN: SRAM model corrupts bit 0 at addr 0x00005 -> verify_err rises after that word's VERIFY and stays 1 for subsequent correct words.

Source files
------------

// File: rtl/sram_fifo_drain_pkg.sv
// Shared types and constants for the SRAM FIFO drain block.
// Optional read-back verify path: SRAM_FIFO_DRAIN_VERIFY_EN.
package sram_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned WAIT_W     = 4;

  // SRAM strobes are active-low
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_VERIFY
  } drain_state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sram_fifo_drain_if.sv
// FIFO-side and SRAM-side signal bundle of the drain block.
// master = drain engine, slave = surrounding FIFO/SRAM/controller.
// Optional verify signals under SRAM_FIFO_DRAIN_VERIFY_EN.
interface sram_fifo_drain_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 18
);
  logic              enable;
  logic [ADDR_W-1:0] base_addr;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_data;
  logic              fifo_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              busy;
  logic              frame_done;
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
  logic [DATA_W-1:0] sram_dq_i;
  logic              verify_err;
`endif

  modport master (
    input  enable, base_addr, fifo_empty, fifo_data,
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
    input  sram_dq_i,
    output verify_err,
`endif
    output fifo_rd_en, sram_addr, sram_dq_o, sram_dq_oe,
    output sram_ce_n, sram_we_n, sram_oe_n, busy, frame_done
  );

  modport slave (
    output enable, base_addr, fifo_empty, fifo_data,
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
    output sram_dq_i,
    input  verify_err,
`endif
    input  fifo_rd_en, sram_addr, sram_dq_o, sram_dq_oe,
    input  sram_ce_n, sram_we_n, sram_oe_n, busy, frame_done
  );

endinterface

// File: rtl/sram_fifo_drain_wait_timer.sv
// Loadable down-counter timing the SRAM strobe phases; done when zero.
module sram_wait_timer
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              done_o
);

  logic [WAIT_W-1:0] cnt_q;

  // load has priority over decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_fifo_drain.sv
// Pops {last,data} words from the pixel FIFO and writes them to an async
// SRAM at sequential addresses with programmable we_n wait-states.
// Optional read-back verify: define SRAM_FIFO_DRAIN_VERIFY_EN.
module sram_fifo_drain
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                clk,
  input logic                rst_n,
  sram_fifo_drain_if.master  bus
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  drain_state_t      state_q;
  logic [ADDR_W-1:0] addr_reg_q;
  logic              frame_active_q;
  logic              word_last_q;
  logic              rd_en_q;
  logic              ce_n_q;
  logic              we_n_q;
  logic              dq_oe_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [DATA_W-1:0] dq_out_q;
  logic              busy_q;
  logic              frame_done_q;
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
  logic              oe_n_q;
  logic              verify_err_q;
`endif

  logic start_ok;
  logic word_end;
  logic timer_load;
  logic timer_dec;
  logic timer_done;

  assign start_ok = bus.enable && !bus.fifo_empty;

  // timer control and end-of-word detection
  always_comb begin
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    word_end   = 1'b0;
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
    timer_load = (state_q == ST_SETUP) || (state_q == ST_HOLD);
    timer_dec  = ((state_q == ST_WRITE) || (state_q == ST_VERIFY)) && !timer_done;
    word_end   = (state_q == ST_VERIFY) && timer_done;
`else
    timer_load = (state_q == ST_SETUP);
    timer_dec  = (state_q == ST_WRITE) && !timer_done;
    word_end   = (state_q == ST_HOLD);
`endif
  end

  sram_wait_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (timer_dec),
    .done_o     (timer_done)
  );

  // drain FSM with registered strobes; outputs are set on the edge entering each state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_reg_q     <= '0;
      frame_active_q <= 1'b0;
      word_last_q    <= 1'b0;
      rd_en_q        <= 1'b0;
      ce_n_q         <= STROBE_OFF;
      we_n_q         <= STROBE_OFF;
      dq_oe_q        <= 1'b0;
      addr_out_q     <= '0;
      dq_out_q       <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
      oe_n_q         <= STROBE_OFF;
      verify_err_q   <= 1'b0;
`endif
    end else begin
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            if (!frame_active_q) begin
              addr_reg_q     <= bus.base_addr;
              frame_active_q <= 1'b1;
            end
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_POP;
          end
        end
        ST_POP: begin
          // the pop is gated by fifo_empty; if it was suppressed there is no word to latch
          if (bus.fifo_empty) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          word_last_q <= bus.fifo_data[DATA_W];
          dq_out_q    <= bus.fifo_data[DATA_W-1:0];
          addr_out_q  <= addr_reg_q;
          ce_n_q      <= STROBE_ON;
          dq_oe_q     <= 1'b1;
          state_q     <= ST_SETUP;
        end
        ST_SETUP: begin
          we_n_q  <= STROBE_ON;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (timer_done) begin
            we_n_q  <= STROBE_OFF;
            state_q <= ST_HOLD;
`ifndef SRAM_FIFO_DRAIN_VERIFY_EN
            frame_done_q <= word_last_q;
`endif
          end
        end
        ST_HOLD: begin
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
          dq_oe_q <= 1'b0;
          oe_n_q  <= STROBE_ON;
          state_q <= ST_VERIFY;
`endif
        end
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
        ST_VERIFY: begin
          if (timer_done) begin
            oe_n_q       <= STROBE_OFF;
            frame_done_q <= word_last_q;
            if (bus.sram_dq_i != dq_out_q) begin
              verify_err_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase

      // word completion overrides the case defaults; a frame ending with more
      // data waiting goes straight to POP, so the new base is captured here
      if (word_end) begin
        ce_n_q  <= STROBE_OFF;
        dq_oe_q <= 1'b0;
        if (start_ok) begin
          rd_en_q    <= 1'b1;
          state_q    <= ST_POP;
          addr_reg_q <= word_last_q ? bus.base_addr : addr_reg_q + 1'b1;
        end else begin
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
          addr_reg_q <= addr_reg_q + 1'b1;
          if (word_last_q) begin
            frame_active_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.fifo_rd_en = rd_en_q && !bus.fifo_empty;
  assign bus.sram_addr  = addr_out_q;
  assign bus.sram_dq_o  = dq_out_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.verify_err = verify_err_q;
`else
  assign bus.sram_oe_n  = STROBE_OFF;
`endif

endmodule

// File: tb/tb_sram_fifo_drain.sv
// Randomized bench for sram_fifo_drain with FIFO/SRAM models and a
// push-time address reference model. Covers SRAM_FIFO_DRAIN_VERIFY_EN if defined.
module tb_sram_fifo_drain;
  import sram_pkg::*;

  localparam int unsigned WS = 2;
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
  localparam int unsigned GAP = 5 + WS + WS + 1;
`else
  localparam int unsigned GAP = 5 + WS;
`endif

  typedef struct {
    logic        last;
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic push_valid;
  logic [16:0] push_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [16:0] fq[$];
  wr_t         exp_q[$];
  logic [15:0] mem[logic [17:0]];
  int unsigned rd_times[$];
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  int unsigned fd_cnt = 0;
  int unsigned cyc = 0;

  logic        m_in_frame = 1'b0;
  logic [17:0] m_addr = '0;

  sram_fifo_drain_if #(.DATA_W(16), .ADDR_W(18)) bus_if ();

  sram_fifo_drain #(
    .DATA_W      (16),
    .ADDR_W      (18),
    .WAIT_STATES (WS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // FIFO model: registered dataOut one cycle after the pop, registered empty flag
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      bus_if.fifo_empty <= 1'b1;
      bus_if.fifo_data  <= '0;
    end else begin
      if (bus_if.fifo_rd_en && fq.size() > 0) bus_if.fifo_data <= fq.pop_front();
      if (push_valid) fq.push_back(push_data);
      bus_if.fifo_empty <= (fq.size() == 0);
    end
  end

  // SRAM-side monitor: captures each write and compares it with the reference queue
  int unsigned lowcnt = 0;
  logic [17:0] w_addr;
  logic [15:0] w_dq;
  always @(negedge clk) begin
    logic hold_cyc;
    wr_t  e;
    hold_cyc = 1'b0;
    cyc++;
    if (!rst_n) begin
      lowcnt = 0;
      exp_q.delete();
    end else begin
      if (bus_if.fifo_rd_en) begin
        chk("rd_while_empty", 32'(bus_if.fifo_empty), 0);
        rd_times.push_back(cyc);
        rd_cnt++;
      end
      if (bus_if.sram_we_n === 1'b0) begin
        if (lowcnt == 0) begin
          w_addr = bus_if.sram_addr;
          w_dq   = bus_if.sram_dq_o;
          chk("we_ce_n", 32'(bus_if.sram_ce_n), 0);
          chk("we_dq_oe", 32'(bus_if.sram_dq_oe), 1);
        end else begin
          chk("we_addr_stable", 32'(bus_if.sram_addr), 32'(w_addr));
          chk("we_dq_stable", 32'(bus_if.sram_dq_o), 32'(w_dq));
        end
        lowcnt++;
      end else if (lowcnt > 0) begin
        hold_cyc = 1'b1;
        chk("we_width", lowcnt, WS + 1);
        chk("hold_ce_n", 32'(bus_if.sram_ce_n), 0);
        chk("hold_dq_oe", 32'(bus_if.sram_dq_oe), 1);
        chk("hold_addr", 32'(bus_if.sram_addr), 32'(w_addr));
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(w_addr), 32'h7FFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(w_addr), 32'(e.addr));
          chk("wr_data", 32'(w_dq), 32'(e.data));
`ifndef SRAM_FIFO_DRAIN_VERIFY_EN
          chk("frame_done_hold", 32'(bus_if.frame_done), 32'(e.last));
`endif
        end
        mem[w_addr] = w_dq;
        wr_cnt++;
        lowcnt = 0;
      end
      if (bus_if.frame_done) fd_cnt++;
`ifndef SRAM_FIFO_DRAIN_VERIFY_EN
      if (!hold_cyc) chk("frame_done_spurious", 32'(bus_if.frame_done), 0);
      chk("oe_n_const", 32'(bus_if.sram_oe_n), 1);
`else
      // read-back data, with bit 0 stuck wrong at address 5
      if (mem.exists(bus_if.sram_addr))
        bus_if.sram_dq_i = mem[bus_if.sram_addr] ^ ((bus_if.sram_addr == 18'h5) ? 16'h1 : 16'h0);
      else
        bus_if.sram_dq_i = '0;
`endif
    end
  end

  // queue one FIFO word and its expected SRAM write; called at posedge+1
  task automatic push_word(input logic last, input logic [15:0] data);
    wr_t w;
    fifo_entry_t fe;
    if (!m_in_frame) begin
      m_addr     = bus_if.base_addr;
      m_in_frame = 1'b1;
    end
    w.last = last;
    w.addr = m_addr;
    w.data = data;
    exp_q.push_back(w);
    m_addr = m_addr + 18'd1;
    if (last) m_in_frame = 1'b0;
    fe.last    = last;
    fe.data    = data;
    push_data  = fe;
    push_valid = 1'b1;
    @(posedge clk);
    #1 push_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus_if.busy || !bus_if.fifo_empty || exp_q.size() != 0) && n < 3000);
    chk({tag, "_drained"}, 32'(n < 3000), 1);
    chk({tag, "_busy"}, 32'(bus_if.busy), 0);
    chk({tag, "_ce_n"}, 32'(bus_if.sram_ce_n), 1);
    chk({tag, "_dq_oe"}, 32'(bus_if.sram_dq_oe), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned r0, w0, f0, t0, n, len, gap;
    rst_n      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    bus_if.enable    = 1'b0;
    bus_if.base_addr = '0;
`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
    bus_if.sram_dq_i = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(bus_if.fifo_rd_en), 0);
    chk("rst_ce_n", 32'(bus_if.sram_ce_n), 1);
    chk("rst_we_n", 32'(bus_if.sram_we_n), 1);
    chk("rst_oe_n", 32'(bus_if.sram_oe_n), 1);
    chk("rst_dq_oe", 32'(bus_if.sram_dq_oe), 0);
    chk("rst_addr", 32'(bus_if.sram_addr), 0);
    chk("rst_dq", 32'(bus_if.sram_dq_o), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_frame_done", 32'(bus_if.frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single word, then a closing word at the incremented address
    bus_if.base_addr = 18'h00100;
    bus_if.enable    = 1'b1;
    r0 = rd_cnt;
    push_word(1'b0, 16'hABCD);
    wait_idle("single");
    chk("single_rd_pulses", rd_cnt - r0, 1);
    f0 = fd_cnt;
    push_word(1'b1, 16'h1234);
    wait_idle("close");
    chk("close_frame_done", fd_cnt - f0, 1);

    // back-to-back stream across the address wrap
    bus_if.base_addr = 18'h3FFFE;
    f0 = fd_cnt;
    t0 = rd_times.size();
    for (int i = 0; i < 4; i++) push_word(i == 3, 16'(16'h5A00 + i));
    wait_idle("stream");
    chk("stream_frame_done", fd_cnt - f0, 1);
    chk("stream_rd_count", rd_times.size() - t0, 4);
    for (int i = 1; i < 4; i++)
      if (rd_times.size() >= t0 + 4)
        chk("stream_rd_gap", rd_times[t0+i] - rd_times[t0+i-1], GAP);

    // random frames with random gaps, letting the FIFO run empty between words
    for (int f = 0; f < 6; f++) begin
      bus_if.base_addr = 18'($urandom_range(32'h3FFFF, 32'h100));
      len = $urandom_range(5, 1);
      f0  = fd_cnt;
      for (int i = 0; i < int'(len); i++) begin
        push_word(i == int'(len) - 1, 16'($urandom));
        gap = $urandom_range(9, 0);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      wait_idle("rand");
      chk("rand_frame_done", fd_cnt - f0, 1);
    end

    // drop enable while word 2 of 3 is being written
    bus_if.base_addr = 18'h20000;
    r0 = rd_cnt;
    w0 = wr_cnt;
    f0 = fd_cnt;
    for (int i = 0; i < 3; i++) push_word(i == 2, 16'(16'hC000 + i));
    n = 0;
    while (rd_cnt < r0 + 2 && n < 200) begin @(negedge clk); n++; end
    while (bus_if.sram_we_n !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    chk("drop_reached_write", 32'(n < 200), 1);
    bus_if.enable = 1'b0;
    repeat (30) @(negedge clk);
    chk("drop_rd_count", rd_cnt - r0, 2);
    chk("drop_wr_count", wr_cnt - w0, 2);
    chk("drop_busy", 32'(bus_if.busy), 0);
    chk("drop_fifo_left", 32'(bus_if.fifo_empty), 0);
    bus_if.enable = 1'b1;
    @(posedge clk);
    #1;
    wait_idle("drop_resume");
    chk("drop_rd_total", rd_cnt - r0, 3);
    chk("drop_frame_done", fd_cnt - f0, 1);

    // reset in the middle of a write
    bus_if.base_addr = 18'h2A000;
    push_word(1'b0, 16'h1111);
    push_word(1'b1, 16'h2222);
    n = 0;
    while (bus_if.sram_we_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("rst_mid_reached_write", 32'(n < 100), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we_n", 32'(bus_if.sram_we_n), 1);
    chk("rst_mid_ce_n", 32'(bus_if.sram_ce_n), 1);
    chk("rst_mid_dq_oe", 32'(bus_if.sram_dq_oe), 0);
    chk("rst_mid_busy", 32'(bus_if.busy), 0);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    m_in_frame = 1'b0;
    @(posedge clk);
    #1;
    bus_if.base_addr = 18'h01230;
    f0 = fd_cnt;
    push_word(1'b0, 16'h3333);
    push_word(1'b1, 16'h4444);
    wait_idle("post_rst");
    chk("post_rst_frame_done", fd_cnt - f0, 1);

`ifdef SRAM_FIFO_DRAIN_VERIFY_EN
    chk("verify_err_clear", 32'(bus_if.verify_err), 0);
    bus_if.base_addr = 18'h00003;
    for (int i = 0; i < 5; i++) push_word(i == 4, 16'($urandom));
    wait_idle("verify_bad");
    chk("verify_err_set", 32'(bus_if.verify_err), 1);
    bus_if.base_addr = 18'h00200;
    for (int i = 0; i < 2; i++) push_word(i == 1, 16'($urandom));
    wait_idle("verify_good");
    chk("verify_err_sticky", 32'(bus_if.verify_err), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
